// File: rtl/serial_pkg.sv
// Shared types and register map for the UART receiver: FSM states, MMIO offsets
// and STATUS bit positions.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    localparam logic [31:0] REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    localparam int STAT_NEMPTY    = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous receive FIFO; head reads as zero while empty. A push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_rx.sv
// 16x-oversampling UART receiver (8N1) with receive FIFO and a two-register
// MMIO read interface (DATA pops, STATUS clears the sticky error flags).
//
// state   | meaning
// S_IDLE  | line idle, waiting for rx_s low
// S_START | start bit seen, re-check it at mid-bit (8th tick)
// S_DATA  | sampling 8 data bits every 16 ticks, LSB first
// S_STOP  | sampling stop bit; high pushes byte, low flags frame error
module serial_rx
    import serial_pkg::*;
#(
    parameter int TICK_DIV   = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        sel,
    input  logic        re,
    input  logic [31:0] addr,
    output logic [31:0] dout
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    rx_state_t   state, state_next;
    logic        rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic        tick;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        frame_err, overrun;
    logic        clr_tick, clr_os, clr_bit, shift_en, push_req, frame_set;
    logic        acc, is_data, is_stat, pop_req, stat_rd, ovr_set;
    logic [7:0]  head;
    logic        full, empty;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:3], addr[1:0]};
    assign tick        = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_tick   = 1'b0;
        clr_os     = 1'b0;
        clr_bit    = 1'b0;
        shift_en   = 1'b0;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    clr_tick   = 1'b1;
                    clr_os     = 1'b1;
                end
            end
            S_START: begin
                if (tick && os_cnt == 4'd7) begin
                    if (!rx_s) begin
                        state_next = S_DATA;
                        clr_os     = 1'b1;
                        clr_bit    = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && os_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && os_cnt == 4'd15) begin
                    push_req   = rx_s;
                    frame_set  = ~rx_s;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // os_cnt is 4 bits wide so it wraps 15->0 on its own between data bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (clr_tick || tick) div_cnt <= '0;
            else                  div_cnt <= div_cnt + 1'b1;

            if (clr_os)    os_cnt <= '0;
            else if (tick) os_cnt <= os_cnt + 1'b1;

            if (clr_bit)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;

            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign acc     = sel & re;
    assign is_data = (addr[2] == REG_DATA[2]);
    assign is_stat = (addr[2] == REG_STATUS[2]);
    assign pop_req = acc & is_data & ~empty;
    assign stat_rd = acc & is_stat;
    assign ovr_set = push_req & full & ~pop_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (stat_rd) frame_err <= 1'b0;

            if (ovr_set)      overrun <= 1'b1;
            else if (stat_rd) overrun <= 1'b0;
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .din   (shreg),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        dout = '0;
        if (is_stat) begin
            dout[STAT_NEMPTY]    = ~empty;
            dout[STAT_FULL]      = full;
            dout[STAT_OVERRUN]   = overrun;
            dout[STAT_FRAME_ERR] = frame_err;
        end else begin
            dout[8:0] = {~empty, head};
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a table of frame/read steps with hand-written expected
// dout, then scoreboard-checked sequences for overflow, pop-on-stop and reset.
module tb_serial_rx;
    import serial_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        sel   = 1'b0;
    logic        re    = 1'b0;
    logic [31:0] addr  = REG_STATUS;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit         exp_frame = 1'b0;
    bit         exp_ovr   = 1'b0;

    serial_rx #(.TICK_DIV(5), .FIFO_DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .sel   (sel),
        .re    (re),
        .addr  (addr),
        .dout  (dout)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {28'b0, exp_frame, exp_ovr, (exp_q.size() == 8), (exp_q.size() != 0)};
    endfunction

    function automatic logic [31:0] model_data();
        if (exp_q.size() == 0) return 32'h0;
        return {23'b0, 1'b1, exp_q[0]};
    endfunction

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clock);
        addr = a;
        sel  = 1'b1;
        re   = 1'b1;
        #1 d = dout;
        @(posedge clock);
        #1;
        sel  = 1'b0;
        re   = 1'b0;
        addr = REG_STATUS;
    endtask

    task automatic sb_read_data(input string name);
        logic [31:0] d, e;
        e = model_data();
        mmio_read(REG_DATA, d);
        check(name, d, e);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic sb_read_status(input string name);
        logic [31:0] d, e;
        e = model_status();
        mmio_read(REG_STATUS, d);
        check(name, d, e);
        exp_frame = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // One frame, 80 clocks per bit, rx changed on negedges k = 0..799.
    // Detect edge is the 3rd posedge after k=0, so the stop sample lands on
    // posedge 763: dout shows the push at negedge 763, not yet at 762.
    // A low stop bit is released at k=770 so the restart it causes is rejected.
    task automatic send_frame(input logic [7:0] data, input bit stop_hi,
                              input bit lat_chk, input bit stop_rd, input int abort_k);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int k = 0; k < 800; k++) begin
            @(negedge clock);
            if (k == abort_k) begin
                reset = 1'b1;
                rx    = 1'b1;
                exp_q.delete();
                exp_frame = 1'b0;
                exp_ovr   = 1'b0;
                repeat (3) @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (k / 80 == 9 && !stop_hi) rx = (k < 770) ? 1'b0 : 1'b1;
            else                         rx = bits[k / 80];
            if (lat_chk && k == 762) #1 check("push_latency_before", dout, 32'h0);
            if (lat_chk && k == 763) #1 check("push_latency_after", dout, 32'h1);
            if (stop_rd && k == 762) begin
                addr = REG_DATA;
                sel  = 1'b1;
                re   = 1'b1;
                #1 check("pop_on_stop_data", dout, model_data());
                void'(exp_q.pop_front());
            end
            if (stop_rd && k == 763) begin
                sel  = 1'b0;
                re   = 1'b0;
                addr = REG_STATUS;
            end
        end
        if (stop_hi) begin
            if (exp_q.size() < 8) exp_q.push_back(data);
            else                  exp_ovr = 1'b1;
        end else begin
            exp_frame = 1'b1;
        end
        repeat (40) begin
            @(negedge clock);
            rx = 1'b1;
        end
    endtask

    task automatic glitch(input int low_clks);
        @(negedge clock);
        rx = 1'b0;
        repeat (low_clks) @(negedge clock);
        rx = 1'b1;
        repeat (100) @(negedge clock);
    endtask

    typedef enum {OP_SEND, OP_SEND_BAD, OP_GLITCH, OP_RD_DATA, OP_RD_STAT} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  arg;
        logic [31:0] exp;
        bit          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] d;

        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h000, 1'b0, "reset_data"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h000, 1'b0, "reset_status"});
        vecs.push_back('{OP_SEND,     8'h55, 32'h000, 1'b1, "send_55"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h001, 1'b0, "status_55"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h155, 1'b0, "data_55"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h000, 1'b0, "data_empty_a"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h000, 1'b0, "status_after_55"});
        vecs.push_back('{OP_GLITCH,   8'd30, 32'h000, 1'b0, "glitch_30"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h000, 1'b0, "status_glitch"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h000, 1'b0, "data_glitch"});
        vecs.push_back('{OP_SEND_BAD, 8'hA3, 32'h000, 1'b0, "send_a3_bad"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h008, 1'b0, "status_frame_err"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h000, 1'b0, "status_frame_clr"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h000, 1'b0, "data_after_bad"});
        vecs.push_back('{OP_SEND,     8'hC4, 32'h000, 1'b0, "send_c4"});
        vecs.push_back('{OP_SEND,     8'h9E, 32'h000, 1'b0, "send_9e"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h001, 1'b0, "status_two"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h1C4, 1'b0, "data_c4"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h19E, 1'b0, "data_9e"});
        vecs.push_back('{OP_RD_DATA,  8'h00, 32'h000, 1'b0, "data_empty_b"});
        vecs.push_back('{OP_RD_STAT,  8'h00, 32'h000, 1'b0, "status_empty_b"});

        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_SEND:     send_frame(vecs[i].arg, 1'b1, vecs[i].lat, 1'b0, -1);
                OP_SEND_BAD: send_frame(vecs[i].arg, 1'b0, vecs[i].lat, 1'b0, -1);
                OP_GLITCH:   glitch(int'(vecs[i].arg));
                OP_RD_DATA: begin
                    mmio_read(REG_DATA, d);
                    check(vecs[i].name, d, vecs[i].exp);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                default: begin
                    mmio_read(REG_STATUS, d);
                    check(vecs[i].name, d, vecs[i].exp);
                    exp_frame = 1'b0;
                    exp_ovr   = 1'b0;
                end
            endcase
        end

        // nine bytes into an eight-deep FIFO: ninth dropped, overrun flagged
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0, -1);
        check("overflow_model_status", model_status(), 32'h7);
        sb_read_status("overflow_status");
        for (int b = 1; b <= 8; b++) sb_read_data($sformatf("overflow_data_%0d", b));
        sb_read_data("overflow_data_empty");
        sb_read_status("overflow_status_clr");

        // full FIFO, DATA pop on the stop-sample edge of the ninth byte
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h09, 1'b1, 1'b0, 1'b1, -1);
        sb_read_status("pop_on_stop_status");
        for (int b = 2; b <= 9; b++) sb_read_data($sformatf("pop_on_stop_data_%0d", b));
        sb_read_status("pop_on_stop_status_end");

        // reset during data bit 4 clears errors and the partial frame
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 440);
        sb_read_status("reset_mid_status");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        sb_read_status("after_reset_status");
        sb_read_data("after_reset_data_3c");
        sb_read_data("after_reset_data_empty");
        sb_read_status("after_reset_status_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter TICK_DIV, default 5, clocks per 16x-oversample tick (bit period = 16*TICK_DIV clocks; 80 at default).
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries, power of two.
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  UART serial line, idle high, asynchronous to clock.
REQ-006 sel  input  1  MMIO select from address decode.
REQ-007 re  input  1  MMIO read enable; access occurs when sel & re are high at a posedge.
REQ-008 addr  input  32  byte address; only addr[2] decoded (0 = DATA, 1 = STATUS).
REQ-009 dout  output  32  combinational read data for current addr.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer before any use; sampled value is rx_s.
REQ-011 Tick counter SHALL count 0..TICK_DIV-1 and assert a one-clock tick at wrap; it SHALL be cleared on IDLE->START.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: rx_s low -> START, tick count = 0.
REQ-014 START: on 8th tick sample rx_s; low -> DATA (bit index 0, tick count 0), high -> IDLE (glitch, nothing recorded).
REQ-015 DATA: every 16th tick sample rx_s into shift register LSB first; after bit 7 -> STOP.
REQ-016 STOP: on 16th tick sample rx_s; high -> push byte, low -> set frame_err sticky, discard byte; both -> IDLE.
REQ-017 Push to full FIFO SHALL drop the byte and set overrun sticky; FIFO contents unchanged.
REQ-018 Pushed byte SHALL be visible at dout the clock after the stop-bit sample.
REQ-019 DATA read (addr[2]=0): dout = {23'b0, ~empty, head byte}; head byte = 0 when empty.
REQ-020 DATA read access with FIFO non-empty SHALL pop one entry at that posedge; read when empty has no effect.
REQ-021 STATUS read (addr[2]=1): dout = {28'b0, frame_err, overrun, full, ~empty}.
REQ-022 STATUS read access SHALL clear frame_err and overrun at that posedge; a new error on the same cycle wins (stays set).
REQ-023 Push and pop in the same cycle SHALL both occur; occupancy unchanged; legal when full (pop frees slot first).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-025 dout SHALL be valid regardless of sel/re; side effects only on sel & re.

Reset
REQ-026 reset SHALL asynchronously force: FSM IDLE, tick/bit counters 0, shift register 0, FIFO empty (pointers, count 0), frame_err 0, overrun 0, synchronizer flops 1.
REQ-027 After reset dout SHALL read 0 for DATA and 0 for STATUS.
REQ-028 Reset mid-frame SHALL abandon the frame; no partial byte pushed; reception resumes at next falling edge after release.

Structure
REQ-029 Package serial_pkg SHALL hold the FSM state enum, register offset constants (DATA=0x0, STATUS=0x4), and STATUS bit positions.
REQ-030 One sub-module rx_fifo (synchronous FIFO, push/pop/full/empty/head, async active-high reset) SHALL hold the storage; FSM and MMIO logic stay in serial_rx.

Verification
REQ-031 Send 0x55 at 80 clocks/bit -> DATA reads 0x155, then 0x000; STATUS 0x0 throughout except bit0 before the pop.
REQ-032 rx low pulse of 30 clocks -> FSM returns IDLE, STATUS stays 0x0, no FIFO entry.
REQ-033 Send 9 bytes 0x01..0x09 without reads -> STATUS 0x7 (overrun, full, nonempty); DATA reads 0x101..0x108; next STATUS read 0x0.
REQ-034 Send 0xA3 with stop bit held low -> STATUS 0x8, FIFO empty; second STATUS read 0x0.
REQ-035 FIFO full, DATA read on stop-sample cycle of 9th byte -> no overrun, occupancy stays 8, last entry 0x09.
REQ-036 Assert reset during bit 4 of a byte, release, send 0x3C -> only 0x13C readable, STATUS error bits 0.
